// File: rtl/weight_stream_pkg.sv
// Shared types and helpers for the weight stream buffer and its RAM.
package weight_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_BYTE_W = 8;

  function automatic int unsigned lane_count(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

  // Word pointer increment that wraps at the end of the buffer.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
    return (addr + 1) % depth;
  endfunction

endpackage

// File: rtl/weight_buf_ram.sv
// DEPTH x DATA_W simple RAM: one byte-enabled write port, two registered read ports.
module weight_buf_ram
  import weight_stream_pkg::*;
#(
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    BYTE_W    = DEF_BYTE_W,
  parameter int    DEPTH     = 16,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = "",
  localparam int   LANES     = lane_count(DATA_W, BYTE_W)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [LANES-1:0]  wr_be_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rda_en_i,
  input  logic [ADDR_W-1:0] rda_addr_i,
  output logic [DATA_W-1:0] rda_data_o,
  input  logic              rdb_en_i,
  input  logic [ADDR_W-1:0] rdb_addr_i,
  output logic [DATA_W-1:0] rdb_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rda_q;
  logic [DATA_W-1:0] rdb_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be_i[i]) mem_q[wr_addr_i][i*BYTE_W +: BYTE_W] <= wr_data_i[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read registers sample the array before this edge's write lands: old data on collision.
  always_ff @(posedge clk) begin
    if (rda_en_i) rda_q <= mem_q[rda_addr_i];
  end

  always_ff @(posedge clk) begin
    if (rdb_en_i) rdb_q <= mem_q[rdb_addr_i];
  end

  assign rda_data_o = rda_q;
  assign rdb_data_o = rdb_q;

endmodule

// File: rtl/weight_stream_buffer.sv
// Weight buffer with Avalon-MM slave access and a base/length stream sequencer.
module weight_stream_buffer
  import weight_stream_pkg::*;
#(
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    BYTE_W    = DEF_BYTE_W,
  parameter int    DEPTH     = 16,
  parameter string INIT_FILE = "",
  localparam int   ADDR_W    = $clog2(DEPTH),
  localparam int   LANES     = lane_count(DATA_W, BYTE_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_write,
  input  logic              avs_read,
  input  logic [LANES-1:0]  avs_byteenable,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic              st_valid_q;
  logic              st_last_q;
  logic              done_q;
  logic              rd_seen_q;

  logic [DATA_W-1:0] rda_data;
  logic [DATA_W-1:0] rdb_data;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] rdb_addr;
  logic              av_wr;
  logic              av_rd;
  logic              handshake;
  logic              launch;
  logic              advance;

  assign av_wr     = avs_chipselect & avs_write;
  assign av_rd     = avs_chipselect & avs_read;
  assign handshake = st_valid_q & st_ready;
  assign launch    = (state_q == S_IDLE) && start && !abort && (length != '0);
  assign advance   = (state_q == S_STREAM) && handshake && !abort && (rem_q > ONE);
  assign ptr_d     = ADDR_W'(wrap_inc(32'(ptr_q), DEPTH));
  // Next word is fetched on the accepting edge so it is presented the cycle after.
  assign rdb_addr  = launch ? base_addr : ptr_d;

  weight_buf_ram #(
    .DATA_W    (DATA_W),
    .BYTE_W    (BYTE_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk        (clk),
    .wr_en_i    (av_wr),
    .wr_addr_i  (avs_address),
    .wr_be_i    (avs_byteenable),
    .wr_data_i  (avs_writedata),
    .rda_en_i   (av_rd),
    .rda_addr_i (avs_address),
    .rda_data_o (rda_data),
    .rdb_en_i   (launch | advance),
    .rdb_addr_i (rdb_addr),
    .rdb_data_o (rdb_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      st_valid_q <= 1'b0;
      st_last_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (av_rd) rd_seen_q <= 1'b1;
      if (abort && state_q != S_IDLE) begin
        state_q    <= S_IDLE;
        st_valid_q <= 1'b0;
        st_last_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              if (length != '0) begin
                ptr_q   <= base_addr;
                rem_q   <= length;
                state_q <= S_FETCH;
              end else begin
                state_q <= S_DONE;
              end
            end
          end
          S_FETCH: begin
            st_valid_q <= 1'b1;
            st_last_q  <= (rem_q == ONE);
            state_q    <= S_STREAM;
          end
          S_STREAM: begin
            if (handshake) begin
              if (rem_q > ONE) begin
                ptr_q     <= ptr_d;
                rem_q     <= rem_q - ONE;
                st_last_q <= (rem_q - ONE == ONE);
              end else begin
                st_valid_q <= 1'b0;
                st_last_q  <= 1'b0;
                state_q    <= S_DONE;
              end
            end
          end
          S_DONE: begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // The stream word lives in the RAM read register; mask it while nothing is offered.
  assign st_data      = st_valid_q ? rdb_data : '0;
  assign avs_readdata = rd_seen_q ? rda_data : '0;
  assign st_valid     = st_valid_q;
  assign st_last      = st_last_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);

endmodule
